// File: rtl/alien_hit_pkg.sv
// rtl/alien_hit_pkg.sv - shared types and default box sizes for the alien hit tracker
package alien_hit_pkg;

  localparam int DEF_COORD_W = 10;
  localparam int DEF_ALIEN_W = 128;
  localparam int DEF_ALIEN_H = 128;
  localparam int DEF_FB_W    = 64;
  localparam int DEF_FB_H    = 64;

  typedef logic [DEF_COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_HIT
  } state_t;

endpackage

// File: rtl/aabb_overlap.sv
// rtl/aabb_overlap.sv - combinational axis-aligned box overlap test; box A at (a_h,a_v), box B at (b_h,b_v)
// Operands are widened by one bit so coordinate-plus-size never wraps; touching edges do not overlap.
module aabb_overlap #(
  parameter int COORD_W = 10,
  parameter int A_W     = 64,
  parameter int A_H     = 64,
  parameter int B_W     = 128,
  parameter int B_H     = 128
) (
  input  logic [COORD_W-1:0] i_a_h,
  input  logic [COORD_W-1:0] i_a_v,
  input  logic [COORD_W-1:0] i_b_h,
  input  logic [COORD_W-1:0] i_b_v,
  output logic               o_overlap
);

  localparam logic [COORD_W:0] LP_A_W = (COORD_W+1)'(A_W);
  localparam logic [COORD_W:0] LP_A_H = (COORD_W+1)'(A_H);
  localparam logic [COORD_W:0] LP_B_W = (COORD_W+1)'(B_W);
  localparam logic [COORD_W:0] LP_B_H = (COORD_W+1)'(B_H);

  logic [COORD_W:0] w_a_h, w_a_v, w_b_h, w_b_v;
  logic [COORD_W:0] w_a_r, w_a_b, w_b_r, w_b_b;
  logic             w_ovl_h, w_ovl_v;

  assign w_a_h = {1'b0, i_a_h};
  assign w_a_v = {1'b0, i_a_v};
  assign w_b_h = {1'b0, i_b_h};
  assign w_b_v = {1'b0, i_b_v};

  assign w_a_r = w_a_h + LP_A_W;
  assign w_a_b = w_a_v + LP_A_H;
  assign w_b_r = w_b_h + LP_B_W;
  assign w_b_b = w_b_v + LP_B_H;

  assign w_ovl_h   = (w_a_r > w_b_h) && (w_a_h < w_b_r);
  assign w_ovl_v   = (w_a_b > w_b_v) && (w_a_v < w_b_b);
  assign o_overlap = w_ovl_h && w_ovl_v;

endmodule

// File: rtl/alien_hit_tracker.sv
// rtl/alien_hit_tracker.sv - per-frame fireball vs alien-bank collision tracker, one slot scanned per clock
// Optional respawn after RESPAWN_FRAMES frames of all-dead is enabled by defining ALIEN_RESPAWN_EN.
module alien_hit_tracker
  import alien_hit_pkg::*;
#(
  parameter int NUM_ALIENS     = 8,
  parameter int COORD_W        = DEF_COORD_W,
  parameter int ALIEN_W        = DEF_ALIEN_W,
  parameter int ALIEN_H        = DEF_ALIEN_H,
  parameter int FB_W           = DEF_FB_W,
  parameter int FB_H           = DEF_FB_H,
  parameter int SCORE_W        = 16,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  input  logic                          fireball_valid,
  input  logic [COORD_W-1:0]            fireball_h,
  input  logic [COORD_W-1:0]            fireball_v,
  input  logic [NUM_ALIENS*COORD_W-1:0] alien_h,
  input  logic [NUM_ALIENS*COORD_W-1:0] alien_v,
  output logic [NUM_ALIENS-1:0]         alive_mask,
  output logic                          hit_valid,
  output logic [$clog2(NUM_ALIENS)-1:0] hit_idx,
  output logic                          fireball_consumed,
  output logic [SCORE_W-1:0]            score,
  output logic                          all_dead,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_ALIENS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ALIENS - 1);

  if (NUM_ALIENS < 2 || NUM_ALIENS > 32 || RESPAWN_FRAMES < 1) begin : g_param_check
    $error("alien_hit_tracker: parameter out of range");
  end

  state_t                  r_state, w_state_nxt;
  logic [IDX_W-1:0]        r_idx, w_idx_nxt;
  logic [COORD_W-1:0]      r_fb_h, r_fb_v;
  logic [NUM_ALIENS*COORD_W-1:0] r_al_h, r_al_v;
  logic [NUM_ALIENS-1:0]   r_alive;
  logic [IDX_W-1:0]        r_hit_idx;
  logic [SCORE_W-1:0]      r_score;

  logic                    w_all_dead;
  logic                    w_start;
  logic                    w_kill;
  logic                    w_cur_alive;
  logic                    w_overlap;
  logic [COORD_W-1:0]      w_sel_h, w_sel_v;

  assign w_all_dead  = ~|r_alive;
  assign w_start     = (r_state == ST_IDLE) && frame_start && fireball_valid && !w_all_dead;
  assign w_cur_alive = r_alive[r_idx];
  assign w_sel_h     = r_al_h[r_idx*COORD_W +: COORD_W];
  assign w_sel_v     = r_al_v[r_idx*COORD_W +: COORD_W];
  assign w_kill      = (r_state == ST_SCAN) && (w_state_nxt == ST_HIT);

  aabb_overlap #(
    .COORD_W (COORD_W),
    .A_W     (FB_W),
    .A_H     (FB_H),
    .B_W     (ALIEN_W),
    .B_H     (ALIEN_H)
  ) u_overlap (
    .i_a_h     (r_fb_h),
    .i_a_v     (r_fb_v),
    .i_b_h     (w_sel_h),
    .i_b_v     (w_sel_v),
    .o_overlap (w_overlap)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_SCAN;
          w_idx_nxt   = '0;
        end
      end
      ST_SCAN: begin
        if (w_cur_alive && w_overlap) begin
          w_state_nxt = ST_HIT;
        end else if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      ST_HIT:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Snapshot so coordinate changes during a scan are invisible to it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fb_h <= '0;
      r_fb_v <= '0;
      r_al_h <= '0;
      r_al_v <= '0;
    end else if (w_start) begin
      r_fb_h <= fireball_h;
      r_fb_v <= fireball_v;
      r_al_h <= alien_h;
      r_al_v <= alien_v;
    end
  end

  // Kill bookkeeping lands on entry to HIT so it is visible alongside hit_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_idx <= '0;
      r_score   <= '0;
    end else if (w_kill) begin
      r_hit_idx <= r_idx;
      if (r_score != {SCORE_W{1'b1}}) begin
        r_score <= r_score + 1'b1;
      end
    end
  end

`ifdef ALIEN_RESPAWN_EN
  localparam int RC_W = $clog2(RESPAWN_FRAMES + 1);

  logic [RC_W-1:0] r_resp_cnt;
  logic            w_respawn;

  assign w_respawn = w_all_dead && frame_start && (r_resp_cnt == RC_W'(RESPAWN_FRAMES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_cnt <= '0;
    end else if (!w_all_dead) begin
      r_resp_cnt <= '0;
    end else if (frame_start) begin
      r_resp_cnt <= w_respawn ? '0 : r_resp_cnt + 1'b1;
    end
  end
`else
  logic w_respawn;

  assign w_respawn = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alive <= '1;
    end else if (w_respawn) begin
      r_alive <= '1;
    end else if (w_kill) begin
      r_alive[r_idx] <= 1'b0;
    end
  end

  assign alive_mask        = r_alive;
  assign all_dead          = w_all_dead;
  assign hit_valid         = (r_state == ST_HIT);
  assign fireball_consumed = (r_state == ST_HIT);
  assign hit_idx           = r_hit_idx;
  assign score             = r_score;
  assign busy              = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alien_hit_tracker.sv
// tb/tb_alien_hit_tracker.sv - self-checking bench for alien_hit_tracker (honours ALIEN_RESPAWN_EN)
module tb_alien_hit_tracker;
  import alien_hit_pkg::*;

  localparam int N   = 8;
  localparam int CW  = 10;
  localparam int AW  = 128;
  localparam int AH  = 128;
  localparam int FW  = 64;
  localparam int FH  = 64;
  localparam int SW  = 16;
  localparam int RSP = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            frame_start;
  logic            fireball_valid;
  coord_t          fireball_h, fireball_v;
  logic [N*CW-1:0] alien_h, alien_v;
  logic [N-1:0]    alive_mask;
  logic            hit_valid;
  logic [2:0]      hit_idx;
  logic            fireball_consumed;
  logic [SW-1:0]   score;
  logic            all_dead;
  logic            busy;

  int checks = 0;
  int errors = 0;

  alien_hit_tracker #(
    .NUM_ALIENS(N), .COORD_W(CW), .ALIEN_W(AW), .ALIEN_H(AH),
    .FB_W(FW), .FB_H(FH), .SCORE_W(SW), .RESPAWN_FRAMES(RSP)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .fireball_valid(fireball_valid),
    .fireball_h(fireball_h), .fireball_v(fireball_v), .alien_h(alien_h), .alien_v(alien_v),
    .alive_mask(alive_mask), .hit_valid(hit_valid), .hit_idx(hit_idx),
    .fireball_consumed(fireball_consumed), .score(score), .all_dead(all_dead), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: per-frame outcome is decided in closed form when the frame is accepted.
  function automatic bit ovl(int fh, int fv, int ah, int av);
    return (fh + FW > ah) && (fh < ah + AW) && (fv + FH > av) && (fv < av + AH);
  endfunction

  logic [N-1:0]  m_alive;
  logic [SW-1:0] m_score;
  int            m_rem;
  bit            m_pend;
  int            m_slot;
  int            m_hit_idx;
  bit            m_hit_now;
  int            m_cnt;
  bit            m_go;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_alive = '1; m_score = '0; m_rem = 0; m_pend = 0; m_slot = 0;
      m_hit_idx = 0; m_hit_now = 0; m_cnt = 0;
    end else begin
      m_go = (m_rem == 0) && frame_start && fireball_valid && (m_alive != 0);
      m_hit_now = 0;
`ifdef ALIEN_RESPAWN_EN
      if (m_alive == 0) begin
        if (frame_start) begin
          m_cnt++;
          if (m_cnt == RSP) begin
            m_alive = '1;
            m_cnt = 0;
          end
        end
      end else begin
        m_cnt = 0;
      end
`endif
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 1 && m_pend) begin
          m_alive[m_slot] = 1'b0;
          if (m_score != '1) m_score++;
          m_hit_idx = m_slot;
          m_hit_now = 1;
          m_pend = 0;
        end
      end
      if (m_go) begin
        m_pend = 0;
        m_rem  = N;
        for (int j = N - 1; j >= 0; j--) begin
          if (m_alive[j] && ovl(int'(fireball_h), int'(fireball_v),
                                int'(alien_h[j*CW +: CW]), int'(alien_v[j*CW +: CW]))) begin
            m_pend = 1;
            m_slot = j;
            m_rem  = j + 2;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_busy", 32'(busy), 32'(m_rem > 0));
      chk("m_hit_valid", 32'(hit_valid), 32'(m_hit_now));
      chk("m_consumed", 32'(fireball_consumed), 32'(m_hit_now));
      chk("m_hit_idx", 32'(hit_idx), 32'(m_hit_idx));
      chk("m_alive", 32'(alive_mask), 32'(m_alive));
      chk("m_score", 32'(score), 32'(m_score));
      chk("m_all_dead", 32'(all_dead), 32'(m_alive == 0));
    end
  end

  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic frame(input logic v);
    frame_start = 1'b1;
    fireball_valid = v;
    cycle();
    frame_start = 1'b0;
  endtask

  task automatic set_al(input int i, input int h, input int v);
    alien_h[i*CW +: CW] = h[CW-1:0];
    alien_v[i*CW +: CW] = v[CW-1:0];
  endtask

  task automatic set_far();
    for (int i = 0; i < N; i++) set_al(i, 600, 400);
  endtask

  task automatic set_fb(input int h, input int v);
    fireball_h = h[CW-1:0];
    fireball_v = v[CW-1:0];
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (!busy) done = 1;
      else cycle();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_idle busy=1 exp=0 after 20 cycles");
    end
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1; frame_start = 1'b0; fireball_valid = 1'b0;
    set_fb(0, 0); set_far();
    repeat (3) cycle();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_alive", 32'(alive_mask), 32'h FF);
    chk("rst_score", 32'(score), 0);
    chk("rst_hit_valid", 32'(hit_valid), 0);
    chk("rst_hit_idx", 32'(hit_idx), 0);
    rst = 1'b0;
    cycle();

    // Single hit on slot 3: pulse exactly 5 cycles after frame_start.
    set_far(); set_al(3, 150, 120); set_fb(100, 100);
    frame(1'b1);
    repeat (3) cycle();
    chk("single_c4_no_hit", 32'(hit_valid), 0);
    cycle();
    chk("single_hit_valid", 32'(hit_valid), 1);
    chk("single_hit_idx", 32'(hit_idx), 3);
    chk("single_consumed", 32'(fireball_consumed), 1);
    chk("single_alive", 32'(alive_mask), 32'h F7);
    chk("single_score", 32'(score), 1);
    wait_idle();
    chk("single_idx_held", 32'(hit_idx), 3);

    // Slots 2 and 5 overlap: lowest index first, then 5 next frame.
    set_far(); set_al(2, 120, 120); set_al(5, 120, 120);
    frame(1'b1); wait_idle();
    chk("multi_first", 32'(alive_mask), 32'h F3);
    frame(1'b1); wait_idle();
    chk("multi_second", 32'(alive_mask), 32'h D3);
    chk("multi_score", 32'(score), 3);

    // Edge touching misses; one pixel in hits, despite inputs changing mid-scan.
    set_far(); set_al(0, 150, 120); set_fb(86, 100);
    frame(1'b1); wait_idle();
    chk("edge_touch_miss", 32'(alive_mask), 32'h D3);
    set_fb(87, 100);
    frame(1'b1);
    set_fb(600, 0); fireball_valid = 1'b0; set_al(0, 900, 900);
    cycle();
    chk("edge_in_hit", 32'(hit_valid), 1);
    chk("edge_in_idx", 32'(hit_idx), 0);
    chk("edge_in_alive", 32'(alive_mask), 32'h D2);
    wait_idle();
    set_far(); set_al(1, 150, 120); set_fb(100, 56);
    frame(1'b1); wait_idle();
    set_fb(278, 100);
    frame(1'b1); wait_idle();
    chk("edge_v_r_miss", 32'(alive_mask), 32'h D2);

    // Overlap only on dead slot 0: full 8-cycle scan, repeated frame_start ignored.
    set_far(); set_al(0, 150, 120); set_fb(100, 100);
    frame(1'b1);
    n = busy ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) frame_start = 1'b1;
      cycle();
      frame_start = 1'b0;
      if (busy) n++;
    end
    chk("dead_busy_cycles", n, 8);
    chk("dead_alive", 32'(alive_mask), 32'h D2);
    frame(1'b0);
    chk("invalid_no_busy", 32'(busy), 0);
    wait_idle();

    // Reset mid-scan restores everything at once.
    set_far(); set_al(7, 120, 120);
    frame(1'b1);
    repeat (2) cycle();
    rst = 1'b1;
    #1;
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_alive", 32'(alive_mask), 32'h FF);
    chk("rstmid_score", 32'(score), 0);
    chk("rstmid_hit", 32'(hit_valid), 0);
    cycle();
    rst = 1'b0;
    cycle();

    // Kill every alien, then three more frames.
    for (int i = 0; i < N; i++) set_al(i, 120, 120);
    set_fb(100, 100);
    for (int k = 0; k < N; k++) begin
      frame(1'b1);
      wait_idle();
    end
    chk("alldead_flag", 32'(all_dead), 1);
    chk("alldead_mask", 32'(alive_mask), 0);
    chk("alldead_score", 32'(score), 8);
    frame(1'b1); cycle();
    frame(1'b1); cycle();
    chk("alldead_2frames", 32'(alive_mask), 0);
    frame(1'b1);
`ifdef ALIEN_RESPAWN_EN
    chk("respawn_mask", 32'(alive_mask), 32'h FF);
    chk("respawn_flag", 32'(all_dead), 0);
`else
    chk("stay_dead_mask", 32'(alive_mask), 0);
    chk("stay_dead_flag", 32'(all_dead), 1);
`endif
    chk("respawn_score", 32'(score), 8);
    chk("respawn_no_scan", 32'(busy), 0);
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
